// File: rtl/grading_line_sequencer.sv
// grading_line_sequencer: item-driven settle, sample, grade, divert and tally for one grading station
module grading_line_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int PULSE_CYCLES  = 8,
    parameter int CLEAR_TIMEOUT = 64,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             item_present_i,
    input  logic             weight_ok_i,
    input  logic             size_ok_i,
    input  logic             color_ok_i,
    input  logic             clear_counts_i,
    input  logic             fault_ack_i,
    output logic             gate_high_o,
    output logic             gate_medium_o,
    output logic             gate_low_o,
    output logic             gate_reject_o,
    output logic             grade_valid_o,
    output logic [1:0]       grade_o,
    output logic             busy_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] cnt_high_o,
    output logic [CNT_W-1:0] cnt_medium_o,
    output logic [CNT_W-1:0] cnt_low_o,
    output logic [CNT_W-1:0] cnt_reject_o,
    output logic [2:0]       state_o
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETTLE     = 3'd1,
        CLASSIFY   = 3'd2,
        DIVERT     = 3'd3,
        WAIT_CLEAR = 3'd4,
        FAULT      = 3'd5
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] PULSE_LAST  = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] CLEAR_LAST  = 16'(CLEAR_TIMEOUT - 1);

    state_t           state;
    logic [15:0]      timer;
    logic [1:0]       grade;
    logic [1:0]       sensed_grade;
    logic [CNT_W-1:0] cnt [4];

    assign sensed_grade = !weight_ok_i ? 2'd0 : !size_ok_i ? 2'd1 : color_ok_i ? 2'd3 : 2'd2;

    // Item sequencing; the grade is latched once, on the edge that leaves SETTLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            grade <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i && item_present_i) begin
                        state <= SETTLE;
                        timer <= '0;
                    end
                end
                SETTLE: begin
                    if (!item_present_i) begin
                        state <= IDLE;
                    end else if (timer == SETTLE_LAST) begin
                        state <= CLASSIFY;
                        grade <= sensed_grade;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                CLASSIFY: begin
                    state <= DIVERT;
                    timer <= '0;
                end
                DIVERT: begin
                    if (timer == PULSE_LAST) begin
                        state <= WAIT_CLEAR;
                        timer <= '0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                WAIT_CLEAR: begin
                    if (!item_present_i) begin
                        state <= IDLE;
                    end else if (timer == CLEAR_LAST) begin
                        state <= FAULT;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                FAULT: begin
                    if (fault_ack_i && !item_present_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-grade tallies: bumped while in CLASSIFY, saturating, with clear taking priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (clear_counts_i) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (state == CLASSIFY && cnt[grade] != {CNT_W{1'b1}}) begin
            cnt[grade] <= cnt[grade] + 1'b1;
        end
    end

    assign gate_high_o   = state == DIVERT && grade == 2'd3;
    assign gate_medium_o = state == DIVERT && grade == 2'd2;
    assign gate_low_o    = state == DIVERT && grade == 2'd1;
    assign gate_reject_o = state == DIVERT && grade == 2'd0;
    assign grade_valid_o = state == CLASSIFY;
    assign grade_o       = grade;
    assign busy_o        = state != IDLE;
    assign fault_o       = state == FAULT;
    assign state_o       = state;
    assign cnt_high_o    = cnt[3];
    assign cnt_medium_o  = cnt[2];
    assign cnt_low_o     = cnt[1];
    assign cnt_reject_o  = cnt[0];
endmodule

// File: tb/tb_grading_line_sequencer.sv
// tb_grading_line_sequencer: grade table, corner sequences and randomized items against a tally model
module tb_grading_line_sequencer;
    localparam int SETTLE   = 4;
    localparam int PULSE    = 8;
    localparam int CLEAR_TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0, present = 1'b0, weight_ok = 1'b0, size_ok = 1'b0, color_ok = 1'b0;
    logic clear_counts = 1'b0, fault_ack = 1'b0;

    logic       gate_high, gate_medium, gate_low, gate_reject, grade_valid, busy_o, fault_o;
    logic [1:0] grade_o;
    logic [2:0] state_o;
    logic [7:0] cnt_high, cnt_medium, cnt_low, cnt_reject;

    logic       s_gh, s_gm, s_gl, s_gr, s_gv, s_busy, s_fault;
    logic [1:0] s_grade;
    logic [2:0] s_state;
    logic [1:0] s_cnt_high, s_cnt_medium, s_cnt_low, s_cnt_reject;

    int n_checks = 0;
    int n_fail   = 0;
    int exp8 [4];
    int exp2 [4];

    typedef struct {
        bit         w, s, c;
        logic [1:0] grade;
        logic [3:0] gates;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    grading_line_sequencer #(.SETTLE_CYCLES(SETTLE), .PULSE_CYCLES(PULSE), .CLEAR_TIMEOUT(CLEAR_TO), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .item_present_i(present),
        .weight_ok_i(weight_ok), .size_ok_i(size_ok), .color_ok_i(color_ok),
        .clear_counts_i(clear_counts), .fault_ack_i(fault_ack),
        .gate_high_o(gate_high), .gate_medium_o(gate_medium), .gate_low_o(gate_low), .gate_reject_o(gate_reject),
        .grade_valid_o(grade_valid), .grade_o(grade_o), .busy_o(busy_o), .fault_o(fault_o),
        .cnt_high_o(cnt_high), .cnt_medium_o(cnt_medium), .cnt_low_o(cnt_low), .cnt_reject_o(cnt_reject),
        .state_o(state_o)
    );

    grading_line_sequencer #(.SETTLE_CYCLES(SETTLE), .PULSE_CYCLES(PULSE), .CLEAR_TIMEOUT(CLEAR_TO), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .item_present_i(present),
        .weight_ok_i(weight_ok), .size_ok_i(size_ok), .color_ok_i(color_ok),
        .clear_counts_i(clear_counts), .fault_ack_i(fault_ack),
        .gate_high_o(s_gh), .gate_medium_o(s_gm), .gate_low_o(s_gl), .gate_reject_o(s_gr),
        .grade_valid_o(s_gv), .grade_o(s_grade), .busy_o(s_busy), .fault_o(s_fault),
        .cnt_high_o(s_cnt_high), .cnt_medium_o(s_cnt_medium), .cnt_low_o(s_cnt_low), .cnt_reject_o(s_cnt_reject),
        .state_o(s_state)
    );

    function automatic logic [3:0] gates();
        return {gate_high, gate_medium, gate_low, gate_reject};
    endfunction

    function automatic logic [31:0] cnt8(input int g);
        return 32'(g == 3 ? cnt_high : g == 2 ? cnt_medium : g == 1 ? cnt_low : cnt_reject);
    endfunction

    function automatic logic [31:0] cnt2(input int g);
        return 32'(g == 3 ? s_cnt_high : g == 2 ? s_cnt_medium : g == 1 ? s_cnt_low : s_cnt_reject);
    endfunction

    function automatic logic [1:0] model_grade(input bit w, input bit s, input bit c);
        if (!w) return 2'd0;
        if (!s) return 2'd1;
        return c ? 2'd3 : 2'd2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic zero_model();
        for (int g = 0; g < 4; g++) begin
            exp8[g] = 0;
            exp2[g] = 0;
        end
    endtask

    task automatic check_counts();
        for (int g = 0; g < 4; g++) begin
            check($sformatf("cnt8[%0d]", g), cnt8(g), 32'(exp8[g]));
            check($sformatf("cnt2[%0d]", g), cnt2(g), 32'(exp2[g]));
        end
    endtask

    // mode 0: normal item, 1: clear_counts coincident with CLASSIFY, 2: item never leaves (timeout)
    task automatic run_item(input bit w, input bit s, input bit c, input logic [1:0] eg, input logic [3:0] egates, input int mode);
        int lat, on, wc;
        bit bad;
        weight_ok = w; size_ok = s; color_ok = c; enable = 1'b1; present = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!grade_valid && lat < 40);
        check("strobe_latency", 32'(lat), 32'(SETTLE + 1));
        check("grade", 32'(grade_o), 32'(eg));
        if (mode == 1) clear_counts = 1'b1;
        weight_ok = ~w; size_ok = ~s; color_ok = ~c;
        on = 0;
        bad = 1'b0;
        for (int k = 0; k < PULSE + 1; k++) begin
            @(negedge clk);
            clear_counts = 1'b0;
            if (gates() != 4'd0) on++;
            if (gates() != 4'd0 && gates() != egates) bad = 1'b1;
            if (grade_valid) bad = 1'b1;
        end
        check("gate_width", 32'(on), 32'(PULSE));
        check("gate_select", 32'(bad), 32'd0);
        check("wait_clear_state", 32'(state_o), 32'd4);
        check("grade_hold", 32'(grade_o), 32'(eg));
        if (mode == 1) begin
            zero_model();
        end else begin
            exp8[eg] = exp8[eg] < 255 ? exp8[eg] + 1 : 255;
            exp2[eg] = exp2[eg] < 3 ? exp2[eg] + 1 : 3;
        end
        check_counts();
        if (mode == 2) begin
            wc = 1;
            while (state_o == 3'd4 && wc < 200) begin
                @(negedge clk);
                if (state_o == 3'd4) wc++;
            end
            check("timeout_cycles", 32'(wc), 32'(CLEAR_TO));
            check("fault_o", 32'(fault_o), 32'd1);
            check("fault_gates", 32'(gates()), 32'd0);
            fault_ack = 1'b1;
            repeat (3) @(negedge clk);
            check("ack_while_present", 32'(state_o), 32'd5);
            present = 1'b0;
            @(negedge clk);
            fault_ack = 1'b0;
            check("fault_release", 32'(state_o), 32'd0);
        end else begin
            present = 1'b0;
            @(negedge clk);
            check("clear_to_idle", 32'(state_o), 32'd0);
            check("busy_idle", 32'(busy_o), 32'd0);
        end
    endtask

    task automatic run_glitch(input int g);
        bit seen;
        seen = 1'b0;
        weight_ok = 1'b1; size_ok = 1'b1; color_ok = 1'b1; enable = 1'b1; present = 1'b1;
        for (int k = 0; k < g; k++) begin
            @(negedge clk);
            if (grade_valid) seen = 1'b1;
        end
        check("glitch_busy", 32'(busy_o), 32'd1);
        present = 1'b0;
        @(negedge clk);
        check("glitch_idle", 32'(state_o), 32'd0);
        check("glitch_no_strobe", 32'(seen), 32'd0);
        check_counts();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, r;
        bit seen, w, s, c;
        logic [1:0] g;
        tbl[0] = '{1, 1, 1, 2'd3, 4'b1000};
        tbl[1] = '{1, 1, 0, 2'd2, 4'b0100};
        tbl[2] = '{1, 0, 1, 2'd1, 4'b0010};
        tbl[3] = '{1, 0, 0, 2'd1, 4'b0010};
        tbl[4] = '{0, 1, 1, 2'd0, 4'b0001};
        tbl[5] = '{0, 1, 0, 2'd0, 4'b0001};
        tbl[6] = '{0, 0, 1, 2'd0, 4'b0001};
        tbl[7] = '{0, 0, 0, 2'd0, 4'b0001};
        zero_model();

        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_gates", 32'(gates()), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_fault", 32'(fault_o), 32'd0);
        check("rst_strobe", 32'(grade_valid), 32'd0);
        check("rst_grade", 32'(grade_o), 32'd0);
        check_counts();
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_item(tbl[i].w, tbl[i].s, tbl[i].c, tbl[i].grade, tbl[i].gates, 0);

        for (int gl = 1; gl <= SETTLE; gl++) run_glitch(gl);

        run_item(1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 2);

        clear_counts = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
        zero_model();
        check_counts();
        for (int i = 0; i < 5; i++) run_item(1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 0);
        check("sat_high", 32'(s_cnt_high), 32'd3);
        check("nosat_high", 32'(cnt_high), 32'd5);
        run_item(1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 1);
        check("clear_wins", 32'(cnt_high), 32'd0);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            w = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            g = model_grade(w, s, c);
            if (r < 2) run_glitch(int'($urandom_range(1, SETTLE)));
            else run_item(w, s, c, g, 4'b0001 << g, r == 2 ? 1 : 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        weight_ok = 1'b1; size_ok = 1'b1; color_ok = 1'b1; enable = 1'b1; present = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!grade_valid && lat < 40);
        repeat (3) @(negedge clk);
        check("divert_gate_on", 32'(gates()), 32'h8);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_gates", 32'(gates()), 32'd0);
        check("async_rst_state", 32'(state_o), 32'd0);
        zero_model();
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy_o) seen = 1'b1;
        end
        check("enable_blocks", 32'(seen), 32'd0);
        check_counts();
        present = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
